flash_page_loader: RTL

//  Upstream feeder for the SPI flash engine in the Odyssey-II bootloader. Takes the

---
 rtl/flash_page_loader.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/flash_page_loader.sv
// Packs the firmware byte stream into 256-byte pages and drives slot-erase and
// page-write requests to the SPI flash engine over toggle handshakes, verifying each page.
module flash_page_loader #(
  parameter int unsigned MAX_PAGES = 8192,
  parameter logic [25:0] TIMEOUT   = 26'h3FFFFFF
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [1:0]    start_slot,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          rx_last,
  output logic          rx_ready,
  output logic          erase_req,
  output logic          write_req,
  output logic [1:0]    slot_num,
  output logic [2047:0] wr_data,
  input  logic          erase_done,
  input  logic          wr_done,
  input  logic [2047:0] rd_data,
  output logic          busy,
  output logic [12:0]   page_cnt,
  output logic          done,
  output logic          verify_err,
  output logic          timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ERASE  = 3'd1,
    S_FILL   = 3'd2,
    S_WRITE  = 3'd3,
    S_WWAIT  = 3'd4,
    S_VERIFY = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_slot;
  logic            r_erase_req;
  logic            r_write_req;
  logic [2047:0]   r_wr_data;
  logic [7:0]      r_byte_idx;
  logic [13:0]     r_page_cnt;
  logic            r_rx_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_verify_err;
  logic            r_timeout_err;
  logic            r_last_seen;
  logic            r_snap;
  logic [25:0]     r_timer;

  logic            w_accept;
  logic            w_full;
  logic            w_page_end;
  logic            w_timer_exp;
  logic            w_match;
  logic [10:0]     w_bit_hi;

  assign w_accept    = (r_state == S_FILL) && rx_valid && r_rx_ready;
  // page counter is one bit wider than the port so that MAX_PAGES itself is representable
  assign w_full      = (r_page_cnt >= 14'(MAX_PAGES));
  assign w_page_end  = (r_byte_idx == 8'd255) || rx_last;
  assign w_timer_exp = (r_timer == (TIMEOUT - 26'd1));
  assign w_match     = (rd_data == r_wr_data);
  assign w_bit_hi    = 11'd2047 - {r_byte_idx, 3'b000};

  assign rx_ready    = r_rx_ready;
  assign erase_req   = r_erase_req;
  assign write_req   = r_write_req;
  assign slot_num    = r_slot;
  assign wr_data     = r_wr_data;
  assign busy        = r_busy;
  assign page_cnt    = r_page_cnt[12:0];
  assign done        = r_done;
  assign verify_err  = r_verify_err;
  assign timeout_err = r_timeout_err;

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_ERASE;
        else       w_next = S_IDLE;
      end
      S_ERASE: begin
        if (erase_done != r_snap) w_next = S_FILL;
        else if (w_timer_exp)     w_next = S_ERROR;
        else                      w_next = S_ERASE;
      end
      S_FILL: begin
        if (!w_accept)       w_next = S_FILL;
        else if (w_full)     w_next = S_ERROR;
        else if (w_page_end) w_next = S_WRITE;
        else                 w_next = S_FILL;
      end
      S_WRITE: w_next = S_WWAIT;
      S_WWAIT: begin
        if (wr_done != r_snap) w_next = S_VERIFY;
        else if (w_timer_exp)  w_next = S_ERROR;
        else                   w_next = S_WWAIT;
      end
      S_VERIFY: begin
        if (!w_match)         w_next = S_ERROR;
        else if (r_last_seen) w_next = S_DONE;
        else                  w_next = S_FILL;
      end
      S_DONE:  w_next = S_IDLE;
      S_ERROR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register, handshake toggles, page buffer and status flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_slot        <= 2'd0;
      r_erase_req   <= 1'b0;
      r_write_req   <= 1'b0;
      r_wr_data     <= '0;
      r_byte_idx    <= 8'd0;
      r_page_cnt    <= 14'd0;
      r_rx_ready    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_verify_err  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_last_seen   <= 1'b0;
      r_snap        <= 1'b0;
      r_timer       <= 26'd0;
    end else begin
      r_state    <= w_next;
      r_rx_ready <= (w_next == S_FILL);
      r_busy     <= (w_next != S_IDLE);
      r_done     <= (w_next == S_DONE);
      if (((w_next == S_ERASE) && (r_state != S_ERASE)) ||
          ((w_next == S_WWAIT) && (r_state != S_WWAIT))) begin
        r_timer <= 26'd0;
      end else if ((r_state == S_ERASE) || (r_state == S_WWAIT)) begin
        r_timer <= r_timer + 26'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_slot        <= start_slot;
            r_page_cnt    <= 14'd0;
            r_verify_err  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_byte_idx    <= 8'd0;
            r_last_seen   <= 1'b0;
            r_wr_data     <= '1;
            r_snap        <= erase_done;
            r_erase_req   <= ~r_erase_req;
          end
        end
        S_ERASE: begin
          if (w_next == S_ERROR) r_timeout_err <= 1'b1;
        end
        S_FILL: begin
          if (w_accept) begin
            if (w_full) begin
              r_verify_err <= 1'b1;
            end else begin
              r_wr_data[w_bit_hi -: 8] <= rx_data;
              r_byte_idx <= w_page_end ? 8'd0 : (r_byte_idx + 8'd1);
              if (rx_last) r_last_seen <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_snap      <= wr_done;
          r_write_req <= ~r_write_req;
        end
        S_WWAIT: begin
          if (w_next == S_ERROR) r_timeout_err <= 1'b1;
        end
        S_VERIFY: begin
          if (!w_match) begin
            r_verify_err <= 1'b1;
          end else begin
            r_page_cnt <= r_page_cnt + 14'd1;
            // a partial final page must read back as erased 0xFF beyond the image
            if (!r_last_seen) r_wr_data <= '1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
